// File: rtl/led_pattern_seq_if.sv
// Control and display bundle for the LED pattern sequencer.
// The master drives enable/mode; the slave (the sequencer) drives LEDR/step.
interface led_pattern_seq_if #(
  parameter int WIDTH = 3
);
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] LEDR;
  logic             step;

  modport master (
    output enable,
    output mode,
    input  LEDR,
    input  step
  );

  modport slave (
    input  enable,
    input  mode,
    output LEDR,
    output step
  );
endinterface

// File: rtl/led_pattern_seq.sv
// Wind/hazard LED pattern sequencer: calm blink, left/right sweep or off,
// advanced once every DIV enabled clocks by a built-in prescaler.
module led_pattern_seq #(
  parameter int               WIDTH    = 3,
  parameter int               DIV      = 4,
  parameter logic [WIDTH-1:0] CALM_PAT = 3'b101
) (
  input  logic             clk,
  input  logic             reset,
  led_pattern_seq_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_CALM_A  = 3'd1,
    ST_CALM_B  = 3'd2,
    ST_SWEEP_R = 3'd3,
    ST_SWEEP_L = 3'd4
  } state_t;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick_s;
  state_t           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             step_q;

  function automatic logic [WIDTH-1:0] led_of(input state_t st, input logic [PW-1:0] p);
    case (st)
      ST_CALM_A:              led_of = CALM_PAT;
      ST_CALM_B:              led_of = ~CALM_PAT;
      ST_SWEEP_R, ST_SWEEP_L: led_of = {{(WIDTH-1){1'b0}}, 1'b1} << p;
      default:                led_of = {WIDTH{1'b0}};
    endcase
  endfunction

  // Prescaler: counts enabled cycles and flags the wrap as the step tick.
  always_comb begin
    tick_s = 1'b0;
    cnt_d  = cnt_q;
    if (bus.enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = {CW{1'b0}};
        tick_s = 1'b1;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pattern next-state: a mode change on a tick reloads the start state, else advance.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    mode_d  = mode_q;
    if (tick_s) begin
      if (bus.mode != mode_q) begin
        mode_d = bus.mode;
        case (bus.mode)
          2'b00:   begin state_d = ST_CALM_A;  pos_d = {PW{1'b0}}; end
          2'b01:   begin state_d = ST_SWEEP_R; pos_d = POS_LAST;   end
          2'b10:   begin state_d = ST_SWEEP_L; pos_d = {PW{1'b0}}; end
          default: begin state_d = ST_OFF;     pos_d = {PW{1'b0}}; end
        endcase
      end else begin
        case (state_q)
          ST_CALM_A:  state_d = ST_CALM_B;
          ST_CALM_B:  state_d = ST_CALM_A;
          ST_SWEEP_R: pos_d = (pos_q == {PW{1'b0}}) ? POS_LAST : pos_q - PW'(1);
          ST_SWEEP_L: pos_d = (pos_q == POS_LAST) ? {PW{1'b0}} : pos_q + PW'(1);
          default:    state_d = ST_OFF;
        endcase
      end
    end else begin
      state_d = state_q;
    end
    led_d = led_of(state_d, pos_d);
  end

  // State and registered outputs; step echoes the tick one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= {CW{1'b0}};
      state_q <= ST_OFF;
      pos_q   <= {PW{1'b0}};
      mode_q  <= 2'b11;
      led_q   <= {WIDTH{1'b0}};
      step_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pos_q   <= pos_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      step_q  <= tick_s;
    end
  end

  assign bus.LEDR = led_q;
  assign bus.step = step_q;
endmodule
